// File: rtl/store_unit.sv
// Store path of the data memory interface: aligns rs2 into byte lanes,
// holds a write request until the bus accepts it, and flags misaligned stores.
module store_unit (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        store_req_in,
  input  logic [1:0]  funct3_in,
  input  logic [31:0] iadder_in,
  input  logic [31:0] rs2_in,
  input  logic        flush_in,
  input  logic        bus_ready_in,
  output logic [31:0] ms_addr_out,
  output logic [31:0] ms_data_out,
  output logic [3:0]  ms_wr_mask_out,
  output logic        ms_wr_req_out,
  output logic        store_stall_out,
  output logic        store_done_out,
  output logic        misaligned_store_out,
  output logic        dbg_state_out
);

  // Handshake: ms_wr_req_out is held with stable address/data/mask until a
  // cycle where bus_ready_in is also high; that cycle completes the transfer.
  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0]  r_mask;
  logic        r_done;
  logic        r_misaligned;

  logic        w_aligned;
  logic        w_accept;
  logic        w_misaligned;
  logic [31:0] w_data;
  logic [3:0]  w_mask;

  always_comb begin
    w_aligned = 1'b1;
    w_data    = rs2_in;
    w_mask    = 4'b1111;
    case (funct3_in)
      2'b00: begin
        w_data = {4{rs2_in[7:0]}};
        w_mask = 4'b0001 << iadder_in[1:0];
      end
      2'b01: begin
        w_aligned = ~iadder_in[0];
        w_data    = {2{rs2_in[15:0]}};
        w_mask    = iadder_in[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_aligned = (iadder_in[1:0] == 2'b00);
      end
    endcase
  end

  assign w_accept     = (r_state == IDLE) & store_req_in & ~flush_in & w_aligned;
  assign w_misaligned = (r_state == IDLE) & store_req_in & ~flush_in & ~w_aligned;

  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept)     w_next_state = REQ;
      REQ:     if (bus_ready_in) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Transfer registers only load on accept and keep their value otherwise.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_addr       <= 32'd0;
      r_data       <= 32'd0;
      r_mask       <= 4'd0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= {iadder_in[31:2], 2'b00};
        r_data <= w_data;
        r_mask <= w_mask;
      end
      r_done       <= (r_state == REQ) & bus_ready_in;
      r_misaligned <= w_misaligned;
    end
  end

  always_comb begin
    ms_addr_out          = r_addr;
    ms_data_out          = r_data;
    ms_wr_mask_out       = r_mask;
    ms_wr_req_out        = (r_state == REQ);
    store_stall_out      = (r_state == REQ) | w_accept;
    store_done_out       = r_done;
    misaligned_store_out = r_misaligned;
    dbg_state_out        = (r_state == REQ);
  end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-write side of the RISC-V core's data path: the store-path counterpart of the load unit, whose output the writeback stage selects. It takes a store instruction's effective address (from the immediate adder), its rs2 data and size, then drives the aligned word, byte-lane mask and a held write request to the data bus. It stalls the pipeline until the bus accepts the transfer and flags misaligned stores instead of issuing them.

## Interface

Parameters:
- None; data and address width is fixed at 32 bits.

Ports:
- clk_in  input  1  core clock; all state updates on the rising edge
- rst_in  input  1  reset, synchronous, active-high
- store_req_in  input  1  decoded store instruction present this cycle
- funct3_in  input  2  size: 00 byte, 01 halfword, 10 word, 11 treated as word
- iadder_in  input  32  effective byte address
- rs2_in  input  32  store source data
- flush_in  input  1  pipeline flush; suppresses acceptance of a new store
- bus_ready_in  input  1  bus accepts the held write this cycle
- ms_addr_out  output  32  word address, {addr[31:2],2'b00}
- ms_data_out  output  32  lane-replicated write data
- ms_wr_mask_out  output  4  byte-lane enables, bit i = byte lane i
- ms_wr_req_out  output  1  write request, held until accepted
- store_stall_out  output  1  stall to the pipeline
- store_done_out  output  1  one-cycle pulse when the write is accepted
- misaligned_store_out  output  1  one-cycle pulse on a misaligned store

## Operation

- FSM with two states: IDLE and REQ.
- A store is accepted in IDLE when store_req_in=1, flush_in=0 and the address is aligned.
- Alignment rules:
  - byte: always aligned
  - halfword: iadder_in[0]=0
  - word (funct3 10 or 11): iadder_in[1:0]=00
- On accept, the following are registered and the FSM moves to REQ:
  - ms_addr_out = {iadder_in[31:2],2'b00}
  - data and mask per the rules below
- Data and mask rules:
  - byte: data={4{rs2[7:0]}}, mask=4'b0001<<addr[1:0]
  - halfword: data={2{rs2[15:0]}}, mask=4'b0011 if addr[1]=0, else 4'b1100
  - word: data=rs2, mask=4'b1111
- In REQ, ms_wr_req_out=1 and the address, data and mask stay stable.
- When bus_ready_in=1 in REQ, the transfer is complete:
  - next cycle: FSM in IDLE, ms_wr_req_out=0, store_done_out=1 for one cycle
- Misaligned store in IDLE (store_req_in=1, flush_in=0): no request is issued and no state change occurs; misaligned_store_out pulses next cycle.
- flush_in in IDLE: the store is dropped, with no misaligned pulse and no stall.
- flush_in in REQ: ignored; an issued transfer always completes.
- store_req_in in REQ: ignored; the pipeline is stalled, so the instruction is re-presented once the stall releases.
- Address, data and mask registers keep their last values in IDLE. Only ms_wr_req_out qualifies them.

## Timing

- Reset (rst_in=1 at a clock edge):
  - FSM to IDLE
  - all outputs 0: ms_addr_out, ms_data_out, ms_wr_mask_out, ms_wr_req_out, store_done_out, misaligned_store_out, store_stall_out
- Reset mid-REQ aborts the request: ms_wr_req_out=0 the following cycle.
- store_stall_out is combinational: (state==REQ) | (state==IDLE & store_req_in & ~flush_in & aligned).
  - High in the accept cycle and in every REQ cycle, including the cycle bus_ready_in is sampled.
  - Low the cycle after acceptance by the bus.
- Latency with bus_ready_in already high:
  - accept at cycle N
  - request visible in N+1, accepted in N+1
  - done pulse in N+2
- Minimum spacing between two stores is 2 cycles. A new store can be accepted in the same cycle store_done_out pulses.
- Each bus_ready_in wait cycle adds one REQ cycle.
- bus_ready_in outside REQ has no effect.

## Test plan

- Byte store, addr=0x1000_0003, rs2=0xAABB_CCDD, ready high:
  - ms_addr_out=0x1000_0000, ms_data_out=0xDDDD_DDDD, ms_wr_mask_out=4'b1000
  - request 1 cycle, done pulse, stall 2 cycles
- Halfword at 0x2002, rs2=0x1234_5678, bus_ready_in low for 3 cycles:
  - data 0x5678_5678, mask 4'b1100
  - request held stable for 4 cycles, then done
- Word at 0x0000_0006:
  - misaligned_store_out pulses once, ms_wr_req_out stays 0, stall never asserts
  - repeat with a halfword at 0x0005: same response
- Word store, flush_in asserted in REQ: transfer still completes with mask 4'b1111. Store with flush_in=1 in IDLE: no request, no stall.
- Back-to-back word stores to 0x10 and 0x14, ready high: requests in cycles N+1 and N+3; the second store is accepted in the cycle of the first done pulse.
- rst_in asserted during REQ with ready low: all outputs 0 next cycle, FSM in IDLE; a subsequent store proceeds normally.
